da_dct_accumulator: RTL

// Distributed-arithmetic shift-accumulate engine for one DCT output coefficient, downstream consumer of a
// 3-bit-address / 16-bit coefficient-sum ROM. Accepts 4 two's-complement samples x0..x3, forms a ROM

---
 rtl/da_dct_accumulator_if.sv | 36 +++
 rtl/da_dct_accumulator.sv | 132 +++++++++++++
 2 files changed

// File: rtl/da_dct_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : da_dct_accumulator_if
// Brief    : Sample-in, ROM and result-out signal bundle for the DA DCT engine.
// Revision : 1.0 - initial release
// ============================================================================
interface da_dct_accumulator_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
);
    localparam int ACC_W = DATA_W + COEF_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] x0;
    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] x2;
    logic [DATA_W-1:0] x3;
    logic [2:0]        rom_addr;
    logic              rom_cs;
    logic [COEF_W-1:0] rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  result;

    modport slave (
        input  in_valid, x0, x1, x2, x3, rom_data, out_ready,
        output in_ready, rom_addr, rom_cs, out_valid, result
    );

    modport master (
        output in_valid, x0, x1, x2, x3, rom_data, out_ready,
        input  in_ready, rom_addr, rom_cs, out_valid, result
    );
endinterface
`default_nettype wire

// File: rtl/da_dct_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : da_dct_accumulator
// Brief    : Bit-serial distributed-arithmetic shift-accumulate for one DCT coefficient.
// Revision : 1.0 - initial release
// ============================================================================
module da_dct_accumulator #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    da_dct_accumulator_if.slave        bus
);
    localparam int ACC_W = DATA_W + COEF_W + 1;
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [DATA_W-1:0]        r_x0;
    logic [DATA_W-1:0]        r_x1;
    logic [DATA_W-1:0]        r_x2;
    logic [DATA_W-1:0]        r_x3;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_result;
    logic                     r_out_valid;

    logic                     w_in_ready;
    logic                     w_rom_cs;
    logic [2:0]               w_rom_addr;
    logic [2:0]               w_slice;
    logic                     w_last;
    logic signed [ACC_W-1:0]  w_rom_ext;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [ACC_W-1:0]  w_acc_nxt;

    assign w_slice = {r_x1[DATA_W-1], r_x2[DATA_W-1], r_x3[DATA_W-1]};
    assign w_last  = (r_cnt == CNT_W'(DATA_W - 1));

    // Sign-extending straight to ACC_W keeps negation of the most negative ROM word exact.
    assign w_rom_ext = {{(ACC_W-COEF_W){bus.rom_data[COEF_W-1]}}, bus.rom_data};
    assign w_term    = r_x0[DATA_W-1] ? -w_rom_ext : w_rom_ext;
    // The MSB slice carries the two's-complement sign weight, hence the negated seed.
    assign w_acc_nxt = (r_cnt == '0) ? -w_term : ((r_acc <<< 1) + w_term);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_rom_cs    = 1'b0;
        w_rom_addr  = 3'd0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_rom_cs   = 1'b1;
                w_rom_addr = r_x0[DATA_W-1] ? ~w_slice : w_slice;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x0        <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_x3        <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_state == S_IDLE && bus.in_valid) begin
                r_x0  <= bus.x0;
                r_x1  <= bus.x1;
                r_x2  <= bus.x2;
                r_x3  <= bus.x3;
                r_cnt <= '0;
                r_acc <= '0;
            end else if (r_state == S_RUN) begin
                r_x0  <= {r_x0[DATA_W-2:0], 1'b0};
                r_x1  <= {r_x1[DATA_W-2:0], 1'b0};
                r_x2  <= {r_x2[DATA_W-2:0], 1'b0};
                r_x3  <= {r_x3[DATA_W-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_acc_nxt;
                if (w_last) begin
                    r_result    <= w_acc_nxt;
                    r_out_valid <= 1'b1;
                end
            end else if (r_state == S_DONE && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.rom_cs    = w_rom_cs;
    assign bus.rom_addr  = w_rom_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
endmodule
`default_nettype wire
